// File: rtl/rns_pkg.sv
// rns_pkg: widths, modulus constants and residue bundle for the
// {2^N+1, 2^N, 2^N-1} reverse converter.
package rns_pkg;

  localparam int RNS_NMAX = 16;

  typedef logic [63:0] u64_t;

  typedef struct packed {
    logic [RNS_NMAX:0]   r1;
    logic [RNS_NMAX-1:0] r0;
    logic [RNS_NMAX-1:0] r_1;
  } rns_triple_t;

  function automatic int rc_w_p1(int n);
    return n + 1;
  endfunction

  function automatic int rc_w_0(int n);
    return n;
  endfunction

  function automatic int rc_w_m1(int n);
    return n;
  endfunction

  function automatic int rc_out_w(int n);
    return 3 * n;
  endfunction

  function automatic u64_t rc_m1(int n);
    return (u64_t'(1) << n) - 1;
  endfunction

  function automatic u64_t rc_p1(int n);
    return (u64_t'(1) << n) + 1;
  endfunction

  function automatic u64_t rc_m(int n);
    return (u64_t'(1) << n) * ((u64_t'(1) << (2 * n)) - 1);
  endfunction

  function automatic u64_t rc_half(int n);
    return rc_m(n) >> 1;
  endfunction

  // Non-canonical: r1 above 2^n, or r_1 equal to 2^n-1.
  function automatic logic rc_bad(rns_triple_t t, int n);
    return (u64_t'(t.r1) > rc_p1(n) - 1) ||
           (u64_t'(t.r_1) == rc_m1(n));
  endfunction

endpackage

// File: rtl/rns_mod_sub.sv
// rns_mod_sub: canonical |x - y| mod (2^N+1) when PLUS=1,
// mod (2^N-1) when PLUS=0.
module rns_mod_sub
  import rns_pkg::*;
#(
  parameter int N    = 3,
  parameter bit PLUS = 1'b0
) (
  input  logic [N:0] x_i,
  input  logic [N:0] y_i,
  output logic [N:0] z_o
);

  localparam logic [N+2:0] MV = PLUS ? (N+3)'(rc_p1(N))
                                     : (N+3)'(rc_m1(N));

  logic [N+2:0] d;
  logic [N+2:0] e;

  always_comb begin
    d = {2'b00, x_i} - {2'b00, y_i};
    e = d[N+2] ? d + MV : d;
    // folds 2^N-1 to 0 in the minus modulus
    if (!e[N+2] && (e >= MV)) e = e - MV;
    z_o = e[N:0];
  end

endmodule

// File: rtl/rns_rc_pipe.sv
// rns_rc_pipe: 3-stage signed RNS reverse converter with valid/ready.
// Optional residue checker: RNS_RC_RESIDUE_CHECK_EN.
module rns_rc_pipe
  import rns_pkg::*;
#(
  parameter int N     = 3,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [rc_w_p1(N)-1:0]       r1,
  input  logic [rc_w_0(N)-1:0]        r0,
  input  logic [rc_w_m1(N)-1:0]       r_1,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [rc_out_w(N)-1:0] n_out,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_err
);

  localparam int W = rc_out_w(N);
  localparam logic [W-1:0] M_C    = W'(rc_m(N));
  localparam logic [W-1:0] HALF_C = W'(rc_half(N));

  logic adv;

  logic [N:0] a_d;
  logic [N:0] b_d;
  logic       e_d;

  logic             v1_q;
  logic [N:0]       a_q;
  logic [N:0]       b_q;
  logic [N-1:0]     r0_1_q;
  logic [TAG_W-1:0] tag1_q;
  logic             e1_q;

  logic [N-1:0] am;
  logic [N-1:0] bm;
  logic [N:0]   s;
  logic [N-1:0] dif;
  logic [N-1:0] t_d;
  logic [2*N-1:0] y_d;

  logic             v2_q;
  logic [2*N-1:0]   y_q;
  logic [N-1:0]     r0_2_q;
  logic [TAG_W-1:0] tag2_q;
  logic             e2_q;

  logic [W-1:0] x_w;
  logic [W-1:0] n_d;

  logic             vo_q;
  logic [W-1:0]     n_q;
  logic [TAG_W-1:0] tago_q;
  logic             eo_q;

  assign adv      = !vo_q | out_ready;
  assign in_ready = adv;

  rns_mod_sub #(.N(N), .PLUS(1'b0)) u_sub_m1 (
    .x_i({1'b0, r_1}),
    .y_i({1'b0, r0}),
    .z_o(a_d)
  );

  rns_mod_sub #(.N(N), .PLUS(1'b1)) u_sub_p1 (
    .x_i({1'b0, r0}),
    .y_i(r1),
    .z_o(b_d)
  );

`ifdef RNS_RC_RESIDUE_CHECK_EN
  rns_triple_t trip;
  always_comb begin
    trip     = '0;
    trip.r1  = (RNS_NMAX+1)'(r1);
    trip.r_1 = RNS_NMAX'(r_1);
  end
  assign e_d = rc_bad(trip, N);
`else
  assign e_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      r0_1_q <= '0;
      tag1_q <= '0;
      e1_q   <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a_q    <= a_d;
        b_q    <= b_d;
        r0_1_q <= r0;
        tag1_q <= in_tag;
        e1_q   <= e_d;
      end
    end
  end

  // Reduce an [0,2^N] value into N bits mod 2^N-1 (2^N -> 1).
  function automatic logic [N-1:0] fold(input logic [N:0] x);
    return x[N-1:0] | N'(x[N]);
  endfunction

  always_comb begin
    am  = fold(a_q);
    bm  = fold(b_q);
    s   = {1'b0, am} + {1'b0, ~bm};
    dif = s[N-1:0] + N'(s[N]);
    t_d = {dif[0], dif[N-1:1]};
    if (&t_d) t_d = '0;
    y_d = (2*N)'(b_q) + {t_d, {N{1'b0}}} + (2*N)'(t_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      y_q    <= '0;
      r0_2_q <= '0;
      tag2_q <= '0;
      e2_q   <= 1'b0;
    end else if (adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        y_q    <= y_d;
        r0_2_q <= r0_1_q;
        tag2_q <= tag1_q;
        e2_q   <= e1_q;
      end
    end
  end

  always_comb begin
    x_w = {y_q, r0_2_q};
    n_d = (x_w >= HALF_C) ? x_w - M_C : x_w;
    if (e2_q) n_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vo_q   <= 1'b0;
      n_q    <= '0;
      tago_q <= '0;
      eo_q   <= 1'b0;
    end else if (adv) begin
      vo_q <= v2_q;
      if (v2_q) begin
        n_q    <= n_d;
        tago_q <= tag2_q;
        eo_q   <= e2_q;
      end
    end
  end

  assign out_valid = vo_q;
  assign n_out     = $signed(n_q);
  assign out_tag   = tago_q;
  assign out_err   = eo_q;

endmodule

// File: tb/tb_rns_rc_pipe.sv
// tb_rns_rc_pipe: three converters (N=3,5,8) in lock-step against
// an integer-level model of the signed residue mapping.
module tb_rns_rc_pipe;

  typedef struct {
    longint i;
    bit     e;
    int     tag;
    int     acc;
    int     cnt;
    bit     lat;
  } ent_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic [3:0] in_tag;

  logic [3:0] r1_3;
  logic [2:0] r0_3, rm_3;
  logic rdy3, ov3, oe3;
  logic signed [8:0] n3;
  logic [3:0] tg3;

  logic [5:0] r1_5;
  logic [4:0] r0_5, rm_5;
  logic rdy5, ov5, oe5;
  logic signed [14:0] n5;
  logic [3:0] tg5;

  logic [8:0] r1_8;
  logic [7:0] r0_8, rm_8;
  logic rdy8, ov8, oe8;
  logic signed [23:0] n8;
  logic [3:0] tg8;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int tag_cnt = 0;
  bit nostall = 1'b1;
  ent_t q[$];

  rns_rc_pipe #(.N(3), .TAG_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
    .r1(r1_3), .r0(r0_3), .r_1(rm_3), .in_tag(in_tag),
    .out_valid(ov3), .out_ready(out_ready), .n_out(n3),
    .out_tag(tg3), .out_err(oe3)
  );

  rns_rc_pipe #(.N(5), .TAG_W(4)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy5),
    .r1(r1_5), .r0(r0_5), .r_1(rm_5), .in_tag(in_tag),
    .out_valid(ov5), .out_ready(out_ready), .n_out(n5),
    .out_tag(tg5), .out_err(oe5)
  );

  rns_rc_pipe #(.N(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .r1(r1_8), .r0(r0_8), .r_1(rm_8), .in_tag(in_tag),
    .out_valid(ov8), .out_ready(out_ready), .n_out(n8),
    .out_tag(tg8), .out_err(oe8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint modp(longint v, longint m);
    return ((v % m) + m) % m;
  endfunction

  // Signed value represented by integer v in the range of base n.
  function automatic longint smap(longint v, int n);
    longint m;
    longint x;
    m = (longint'(1) << n) * ((longint'(1) << (2 * n)) - 1);
    x = modp(v, m);
    return (x >= m / 2) ? x - m : x;
  endfunction

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic observe();
    bit ev;
    ev = (q.size() > 0) && (q[0].cnt >= 3);
    chk("out_valid3", ov3, ev);
    chk("out_valid5", ov5, ev);
    chk("out_valid8", ov8, ev);
    if (ev) begin
      chk("n_out3", n3, q[0].e ? 0 : smap(q[0].i, 3));
      chk("n_out5", n5, smap(q[0].i, 5));
      chk("n_out8", n8, smap(q[0].i, 8));
      chk("out_tag3", tg3, q[0].tag);
      chk("out_tag8", tg8, q[0].tag);
      chk("out_err3", oe3, q[0].e);
      chk("out_err8", oe8, 0);
      if (q[0].lat) chk("latency", cyc - q[0].acc, 3);
    end
  endtask

  task automatic step(input bit v, input longint i, input bit ordy,
                      input bit inj, input int ir1, input int ir0,
                      input int irm);
    bit adv;
    bit ee;
    bit ev;
    ent_t en;
    ee = 1'b0;
    observe();
    ev = (q.size() > 0) && (q[0].cnt >= 3);
    in_valid  = v;
    out_ready = ordy;
    in_tag    = 4'(tag_cnt);
    r1_3 = 4'(modp(i, 9));
    r0_3 = 3'(modp(i, 8));
    rm_3 = 3'(modp(i, 7));
    r1_5 = 6'(modp(i, 33));
    r0_5 = 5'(modp(i, 32));
    rm_5 = 5'(modp(i, 31));
    r1_8 = 9'(modp(i, 257));
    r0_8 = 8'(modp(i, 256));
    rm_8 = 8'(modp(i, 255));
    if (inj) begin
      r1_3 = 4'(ir1);
      r0_3 = 3'(ir0);
      rm_3 = 3'(irm);
`ifdef RNS_RC_RESIDUE_CHECK_EN
      ee = (ir1 > 8) || (irm == 7);
`endif
    end
    #1;
    adv = !ev || ordy;
    chk("in_ready3", rdy3, adv);
    chk("in_ready5", rdy5, adv);
    chk("in_ready8", rdy8, adv);
    if (adv) begin
      if (ev && ordy) void'(q.pop_front());
      foreach (q[k]) if (q[k].cnt < 3) q[k].cnt++;
      if (v) begin
        en.i = i; en.e = ee; en.tag = tag_cnt % 16;
        en.acc = cyc; en.cnt = 1; en.lat = nostall;
        q.push_back(en);
        tag_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) step(0, 0, 1, 0, 0, 0, 0);
    chk("drain_empty", q.size(), 0);
  endtask

  longint bnd[8];
  longint ri;

  initial begin
    bnd = '{-252, 251, 0, -1, -16368, 16367, -8388480, 8388479};
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_tag = '0;
    {r1_3, r0_3, rm_3} = '0;
    {r1_5, r0_5, rm_5} = '0;
    {r1_8, r0_8, rm_8} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid3", ov3, 0);
    chk("rst_valid5", ov5, 0);
    chk("rst_valid8", ov8, 0);
    chk("rst_n3", n3, 0);
    chk("rst_n8", n8, 0);
    chk("rst_tag3", tg3, 0);
    chk("rst_err3", oe3, 0);
    rst_n = 1'b1;

    for (longint i = -252; i <= 251; i++) step(1, i, 1, 0, 0, 0, 0);
    foreach (bnd[k]) step(1, bnd[k], 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, -1, 1, 0, 0, 0, 0);
`ifdef RNS_RC_RESIDUE_CHECK_EN
    step(1, 0, 1, 1, 9, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 7);
    step(1, 1, 1, 1, 1, 1, 1);
`endif
    drain();

    nostall = 1'b0;
    for (int k = 0; k < 400; k++) begin
      ri = longint'($urandom_range(0, 16776959)) - 8388480;
      step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 9) >= 3,
           0, 0, 0, 0);
    end
    drain();
    nostall = 1'b1;

    step(1, 17, 1, 0, 0, 0, 0);
    step(1, -18, 1, 0, 0, 0, 0);
    step(1, 19, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid3", ov3, 0);
    chk("midrst_valid8", ov8, 0);
    chk("midrst_n3", n3, 0);
    chk("midrst_tag3", tg3, 0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, -100, 1, 0, 0, 0, 0);
    step(1, 101, 1, 0, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
